// File: rtl/sprite_cmd_queue.sv
// sprite_cmd_queue
//   Avalon-MM write front end for the sprite display blocks. Software posts 32-bit
//   command words into a FIFO; the block replays them one per clock on a shared
//   registered command bus. Buffer-flip words (info field [20:17] == 4'b1111) are
//   held back until vertical blanking, and at most one flip is issued per blanking
//   period. Words queued behind a pending flip wait with it (no reordering).
//
// Optional feature (macro SPRITE_CMD_QUEUE_IRQ_EN):
//   defined   -> irq sets when a flip word is emitted, clears on a control write
//                with bit 1 set (set wins on a same-cycle collision).
//   undefined -> irq is tied to 0 and control bit 1 is ignored.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   chipselect  Avalon slave select
//   write       Avalon write strobe
//   read        Avalon read strobe
//   address     0 = command push / status, 1 = control / flip count
//   writedata   Avalon write data
//   readdata    registered read data (1-cycle latency)
//   vcount      current VGA line from the timing generator
//   cmd_out     command word broadcast to the display blocks, 0 when idle
//   irq         flip interrupt
module sprite_cmd_queue #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned VBLANK_LINE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic        address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out,
    output logic        irq
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_LEVEL  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitVblank
    } state_e;

    state_e state_q, state_d;

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   level_q;
    logic              overflow_q;
    logic              flip_done_q;
    logic [15:0]       frame_count_q;
    logic [31:0]       cmd_q, cmd_d;
    logic [31:0]       rdata_q;

    logic        push_req;
    logic        ctrl_wr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        flip_emit;
    logic        vblank;
    logic [31:0] head;
    logic        head_is_flip;
    logic [31:0] status;

    always_comb begin
        push_req     = chipselect & write & ~address;
        ctrl_wr      = chipselect & write & address;
        full         = (level_q == FULL_LEVEL);
        empty        = (level_q == '0);
        // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
        push         = push_req & ~full;
        vblank       = (32'(vcount) >= VBLANK_LINE);
        head         = mem_q[rd_ptr_q];
        head_is_flip = (head[20:17] == 4'b1111);
    end

    // Issue FSM: pops at most one word per cycle into the cmd_out register.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        flip_emit = 1'b0;
        cmd_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (!empty) state_d = StIssue;
            end
            StIssue: begin
                if (empty) begin
                    state_d = StIdle;
                end else if (!head_is_flip || (vblank && !flip_done_q)) begin
                    pop       = 1'b1;
                    flip_emit = head_is_flip;
                    cmd_d     = head;
                    state_d   = (level_q > ONE_LEVEL) ? StIssue : StIdle;
                end else begin
                    // Flip not allowed yet: the whole queue stalls behind it.
                    state_d = StWaitVblank;
                end
            end
            StWaitVblank: begin
                if (vblank && !flip_done_q) state_d = StIssue;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        status             = '0;
        status[ADDR_W:0]   = level_q;
        status[31]         = overflow_q;
    end

    // Storage has no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= writedata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            flip_done_q   <= 1'b0;
            frame_count_q <= '0;
            cmd_q         <= '0;
            rdata_q       <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            unique case ({push, pop})
                2'b10:   level_q <= level_q + ONE_LEVEL;
                2'b01:   level_q <= level_q - ONE_LEVEL;
                default: level_q <= level_q;
            endcase

            if (push_req && full) begin
                overflow_q <= 1'b1;
            end else if (ctrl_wr && writedata[0]) begin
                overflow_q <= 1'b0;
            end

            // flip_done spans one contiguous blanking run.
            if (!vblank) begin
                flip_done_q <= 1'b0;
            end else if (flip_emit) begin
                flip_done_q <= 1'b1;
            end

            if (flip_emit) frame_count_q <= frame_count_q + 16'd1;

            if (chipselect && read) begin
                rdata_q <= address ? {16'b0, frame_count_q} : status;
            end
        end
    end

`ifdef SPRITE_CMD_QUEUE_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (flip_emit) begin
            irq_q <= 1'b1;
        end else if (ctrl_wr && writedata[1]) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign cmd_out  = cmd_q;
    assign readdata = rdata_q;

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// Testbench for sprite_cmd_queue: a table of per-cycle vectors for the basic
// push/replay/flip/readback behaviour, hand-written multi-cycle sequences for
// flip pacing, overflow and mid-drain reset, and a randomized run checked
// against a queue-based reference model.
module tb_sprite_cmd_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic        address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  vcount;
    logic [31:0] cmd_out;
    logic        irq;

`ifdef SPRITE_CMD_QUEUE_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    localparam logic [31:0] WA = 32'h28220000;
    localparam logic [31:0] WB = 32'h2822A064;
    localparam logic [31:0] WF = 32'h001E2000;

    sprite_cmd_queue dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .vcount     (vcount),
        .cmd_out    (cmd_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        cs;
        logic        wr;
        logic        rd;
        logic        ad;
        logic [31:0] wd;
        logic [9:0]  vc;
        logic [31:0] exp_cmd;
        logic        exp_irq;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic cs, input logic wr, input logic rd, input logic ad,
                                input logic [31:0] wd, input logic [9:0] vc,
                                input logic [31:0] ec, input logic ei,
                                input logic chk, input logic [31:0] er);
        vec_t v;
        v.cs = cs; v.wr = wr; v.rd = rd; v.ad = ad; v.wd = wd; v.vc = vc;
        v.exp_cmd = ec; v.exp_irq = ei; v.chk_rd = chk; v.exp_rd = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 1'b0;
        writedata  = '0;
    endtask

    task automatic do_reset();
        idle_bus();
        reset  = 1'b1;
        vcount = 10'd100;
        tick();
        tick();
        check("reset_cmd", cmd_out, 32'h0);
        check("reset_rd", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        chipselect = 1'b1; write = 1'b1; address = 1'b0; writedata = w;
        tick();
        idle_bus();
    endtask

    task automatic ctrl_write(input logic [31:0] w);
        chipselect = 1'b1; write = 1'b1; address = 1'b1; writedata = w;
        tick();
        idle_bus();
    endtask

    task automatic read_reg(input logic a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        d = readdata;
        idle_bus();
    endtask

    // Count nonzero cmd_out cycles over n edges.
    task automatic quiet_cycles(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (cmd_out != 32'h0) seen++;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    int          seen;
    logic [31:0] exp_q[$];
    int          flips_pushed;
    int          blank_flips;
    int          vc_int;
    int          cyc;
    logic [31:0] w;
    logic [31:0] exp_w;
    logic        cur_flip;

    initial begin
        idle_bus();
        reset  = 1'b1;
        vcount = 10'd100;

        // ---------------- table-driven vectors ----------------
        //          cs  wr  rd  ad  wdata  vc   exp_cmd exp_irq chk exp_rd
        tbl.push_back(mk(1, 1, 0, 0, WA,   100, 32'h0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 0, WB,   100, 32'h0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,    100, WA,    0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,    100, WB,    0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,    100, 32'h0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 0, 0,    100, 32'h0, 0, 1, 32'h0));
        tbl.push_back(mk(1, 0, 1, 1, 0,    100, 32'h0, 0, 1, 32'h0));
        tbl.push_back(mk(1, 1, 0, 0, WF,   100, 32'h0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 0, WA,   100, 32'h0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,    100, 32'h0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,    100, 32'h0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,    100, 32'h0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 0, 0,    100, 32'h0, 0, 1, 32'h2));
        tbl.push_back(mk(0, 0, 0, 0, 0,    480, 32'h0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,    480, WF,    1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,    480, WA,    1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,    480, 32'h0, 1, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 1, 0,    480, 32'h0, 1, 1, 32'h1));
        tbl.push_back(mk(1, 1, 0, 1, 2,    480, 32'h0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 0, 0,    480, 32'h0, 0, 1, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,    100, 32'h0, 0, 0, 32'h0));

        do_reset();
        foreach (tbl[i]) begin
            chipselect = tbl[i].cs;
            write      = tbl[i].wr;
            read       = tbl[i].rd;
            address    = tbl[i].ad;
            writedata  = tbl[i].wd;
            vcount     = tbl[i].vc;
            tick();
            check($sformatf("vec%0d_cmd", i), cmd_out, tbl[i].exp_cmd);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq & IRQ_ON});
            if (tbl[i].chk_rd) check($sformatf("vec%0d_rd", i), readdata, tbl[i].exp_rd);
        end
        idle_bus();

        // ---------------- two flips inside one blanking period ----------------
        do_reset();
        vcount = 10'd490;
        push_word(WF);
        push_word(WF);
        tick();
        check("flip1_emit", cmd_out, WF);
        check("flip1_irq", {31'b0, irq}, {31'b0, IRQ_ON});
        quiet_cycles(10, seen);
        check("flip2_held_blank", seen, 0);
        vcount = 10'd0;
        quiet_cycles(3, seen);
        check("flip2_held_active", seen, 0);
        vcount = 10'd480;
        tick();
        check("flip2_pre", cmd_out, 32'h0);
        tick();
        check("flip2_emit", cmd_out, WF);
        tick();
        check("flip2_single", cmd_out, 32'h0);
        read_reg(1'b1, rd);
        check("flip2_count", rd, 32'h2);

        // ---------------- overflow behind a stalled flip ----------------
        do_reset();
        push_word(WF);
        for (int i = 0; i < 64; i++) push_word(WA | 32'(i + 1));
        check("ovf_cmd_quiet", cmd_out, 32'h0);
        read_reg(1'b0, rd);
        check("ovf_status", rd, 32'h80000040);
        ctrl_write(32'h1);
        read_reg(1'b0, rd);
        check("ovf_cleared", rd, 32'h00000040);

        // ---------------- reset mid-drain ----------------
        do_reset();
        push_word(WF);
        for (int i = 0; i < 10; i++) push_word(WB + 32'(i));
        vcount = 10'd480;
        tick();
        tick();
        check("drain_flip", cmd_out, WF);
        tick();
        check("drain_word0", cmd_out, WB);
        reset = 1'b1;
        tick();
        check("midrst_cmd", cmd_out, 32'h0);
        reset = 1'b0;
        read_reg(1'b0, rd);
        check("midrst_level", rd, 32'h0);
        quiet_cycles(20, seen);
        check("midrst_quiet", seen, 0);

        // ---------------- randomized run vs queue model ----------------
        do_reset();
        flips_pushed = 0;
        blank_flips  = 0;
        vc_int       = 0;
        exp_q.delete();
        for (cyc = 0; cyc < 6000; cyc++) begin
            vc_int = (vc_int + int'($urandom_range(1, 24))) % 525;
            vcount = 10'(vc_int);
            if (vc_int < 480) blank_flips = 0;
            w = '0;
            if (cyc < 3000 && exp_q.size() < 56 && $urandom_range(0, 2) == 0) begin
                w = $urandom;
                if ($urandom_range(0, 9) == 0) begin
                    w[20:17] = 4'b1111;
                    flips_pushed++;
                end else begin
                    w[17] = 1'b0;
                    w[0]  = 1'b1;
                end
                chipselect = 1'b1; write = 1'b1; address = 1'b0; writedata = w;
            end else begin
                idle_bus();
            end
            tick();
            if (cmd_out != 32'h0) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious", cmd_out, 32'h0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("rand_order", cmd_out, exp_w);
                    cur_flip = (cmd_out[20:17] == 4'b1111);
                    if (cur_flip) begin
                        check("rand_flip_in_vblank", {31'b0, vc_int >= 480}, 32'h1);
                        check("rand_one_flip_per_blank", blank_flips, 0);
                        blank_flips++;
                    end
                end
            end
            if (w != 32'h0) exp_q.push_back(w);
            if (cyc >= 3000 && exp_q.size() == 0) break;
        end
        idle_bus();
        check("rand_drained", exp_q.size(), 0);
        tick();
        tick();
        read_reg(1'b1, rd);
        check("rand_frame_count", rd, 32'(flips_pushed & 16'hFFFF));
        read_reg(1'b0, rd);
        check("rand_status", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
